ps2_scancode_rx: RTL and testbench
==================================

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of decoded key events buffered; power of two, 2..64.
REQ-002 Parameter FILTER_LEN, default 8, number of consecutive equal CLOCK_50 samples required before PS2_CLK or PS2_DAT changes filtered level.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000, count of idle CLOCK_50 cycles after which a partial frame is aborted (2 ms at 50 MHz).
REQ-004 CLOCK_50  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-005 RESET_N  input  1  synchronous, active-low reset.
REQ-006 PS2_CLK  input  1  keyboard clock, asynchronous, receive-only.
REQ-007 PS2_DAT  input  1  keyboard data, asynchronous, receive-only.
REQ-008 out_valid  output  1  FIFO head holds an event.
REQ-009 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-010 out_code  output  8  scan code of head event.
REQ-011 out_ext  output  1  head event was preceded by E0.
REQ-012 out_brk  output  1  head event was preceded by F0 (key release).
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH+1)  events currently held.
REQ-014 err_frame  output  1  one-cycle pulse on bad stop bit or timeout abort.
REQ-015 err_parity  output  1  one-cycle pulse on odd-parity failure.
REQ-016 overflow  output  1  sticky; set when an event is dropped because the FIFO is full.

Function
REQ-017 PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser, then a FILTER_LEN-sample glitch filter; filtered levels reset to 1.
REQ-018 A falling edge is a filtered PS2_CLK 1->0 transition; PS2_DAT is sampled at its filtered value in the same cycle.
REQ-019 The FSM has states IDLE, DATA, PARITY, and STOP; it resets to IDLE.
REQ-020 IDLE->DATA on an edge with DAT=0; an edge with DAT=1 in IDLE is ignored.
REQ-021 DATA shifts eight bits LSB-first; after the 8th edge it goes to PARITY.
REQ-022 PARITY captures the bit and goes to STOP.
REQ-023 STOP->IDLE on the next edge; if DAT=0, err_frame pulses and the byte is discarded; if data+parity ones-count is even, err_parity pulses and the byte is discarded.
REQ-024 In any state other than IDLE, TIMEOUT_CYCLES cycles without an edge force IDLE, pulse err_frame, and discard the partial byte; the counter clears on every edge.
REQ-025 Accepted byte E0 sets the ext flag; F0 sets the brk flag; neither is pushed.
REQ-026 Any other accepted byte pushes {ext,brk,code} one cycle after the STOP edge, then clears both flags.
REQ-027 Errors and timeouts also clear the ext and brk flags.
REQ-028 The FIFO is first-word fall-through; out_code, out_ext, and out_brk are valid whenever out_valid=1 and hold stable until popped.
REQ-029 A pop occurs when out_valid and out_ready are both 1.
REQ-030 Empty FIFO: out_valid=0; out_ready is ignored.
REQ-031 Full FIFO with a push and no pop in the same cycle: the event is dropped, overflow is set, and contents are unchanged.
REQ-032 Full FIFO with a push and a pop in the same cycle: both succeed and fifo_count is unchanged.
REQ-033 Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

Reset
REQ-034 While RESET_N=0 at a clock edge, the block resets:
- FSM to IDLE; bit counter, timeout counter, shift register, ext/brk flags, and pointers to 0.
- fifo_count, out_valid, err_frame, err_parity, and overflow to 0.
- out_code, out_ext, and out_brk to 0.
REQ-035 Reset asserted mid-frame discards the frame; the first edge after release with DAT=0 starts a fresh frame.

Configuration
REQ-036 With macro PS2_PARITY_CHECK_EN defined, parity is checked per REQ-023.
REQ-037 Without PS2_PARITY_CHECK_EN, the parity bit is captured but ignored, and err_parity is tied to 0.

Verification
REQ-038 Frame 0x1C with correct parity and stop=1, out_ready=1 -> out_valid pulses with code=1C, ext=0, brk=0.
REQ-039 Bytes E0, F0, 74 with out_ready=0 -> exactly one event {ext=1, brk=1, code=74}; fifo_count=1.
REQ-040 Frame 0x1C with a wrong parity bit -> err_parity pulses once and fifo_count stays 0; with PS2_PARITY_CHECK_EN undefined -> the event is pushed.
REQ-041 Frame stopped after 4 data bits -> err_frame pulses after TIMEOUT_CYCLES cycles; a following valid 0x29 frame is received as code=29.
REQ-042 FIFO_DEPTH=8, out_ready=0, 9 frames 0x01..0x09 -> fifo_count=8 and overflow=1; draining yields 01..08 in order.
REQ-043 A 2-cycle PS2_CLK glitch with FILTER_LEN=8 -> no state change; RESET_N=0 for one cycle mid-frame -> all outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise and filter PS2_CLK/PS2_DAT, deframe bytes, fold E0/F0
// prefixes into key events and buffer them in a FWFT FIFO. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_scancode_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              CLOCK_50,
  input  logic                              RESET_N,
  input  logic                              PS2_CLK,
  input  logic                              PS2_DAT,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [7:0]                        out_code,
  output logic                              out_ext,
  output logic                              out_brk,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              err_frame,
  output logic                              err_parity,
  output logic                              overflow,
  output logic [1:0]                        fsm_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Index 0 carries PS2_CLK, index 1 carries PS2_DAT.
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_prev;
  logic          fall, dat;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      filt     <= 2'b11;
      clk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1    <= {PS2_DAT, PS2_CLK};
      sync2    <= sync1;
      clk_prev <= filt[0];
      // A level is adopted only after FILTER_LEN consecutive samples disagree with it.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_prev & ~filt[0];
  assign dat  = filt[1];

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic          ext_q, brk_q;
  logic          push_pend;
  logic [10:0]   push_data;
  logic          timeout, frame_bad, par_bad, byte_ok, parity_fail;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_fail = ~(^{shift_q, parity_q});
`else
  logic parity_unused;
  assign parity_unused = parity_q;
  assign parity_fail   = 1'b0;
`endif

  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    frame_bad = 1'b0;
    par_bad   = 1'b0;
    byte_ok   = 1'b0;
    timeout   = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE:    if (fall && !dat) state_nxt = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY:  if (fall) state_nxt = STOP;
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          if (!dat)             frame_bad = 1'b1;
          else if (parity_fail) par_bad   = 1'b1;
          else                  byte_ok   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      state_nxt = IDLE;
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      push_pend  <= 1'b0;
      push_data  <= '0;
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
    end else begin
      state      <= state_nxt;
      err_frame  <= frame_bad;
      err_parity <= par_bad;
      push_pend  <= 1'b0;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shift_q <= {dat, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  parity_q <= dat;
          default: ;
        endcase
      end
      if (timeout) bit_cnt <= '0;
      // Prefix bytes only arm flags; any other good byte becomes an event and consumes them.
      if (byte_ok) begin
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          push_pend <= 1'b1;
          push_data <= {ext_q, brk_q, shift_q};
          ext_q     <= 1'b0;
          brk_q     <= 1'b0;
        end
      end
      if (frame_bad || par_bad) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // Output handshake: the head event transfers on any rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and the head is stable until that transfer.
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [10:0]   head;
  logic          pop, full, wr_en;

  assign pop   = out_valid & out_ready;
  assign full  = (fifo_count == CW'(FIFO_DEPTH));
  assign wr_en = push_pend & (~full | pop);

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (push_pend && full && !pop) overflow <= 1'b1;
    end
  end

  assign out_valid = (fifo_count != '0);
  assign head      = mem[rd_ptr];
  assign out_code  = out_valid ? head[7:0] : 8'h00;
  assign out_brk   = out_valid ? head[8]   : 1'b0;
  assign out_ext   = out_valid ? head[9]   : 1'b0;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised bench for ps2_scancode_rx: PS/2 frame driver, event-level reference model,
// popping monitor with expected-event queue, and a one-line report.
module tb_ps2_scancode_rx;

  localparam int FIFO_DEPTH     = 8;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 500;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid, out_ext, out_brk, err_frame, err_parity, overflow;
  logic [7:0] out_code;
  logic [3:0] fifo_count;
  logic [1:0] fsm_state;

  always #10 clk = ~clk;

  ps2_scancode_rx #(
    .FIFO_DEPTH(FIFO_DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLOCK_50(clk), .RESET_N(RESET_N), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_ext(out_ext), .out_brk(out_brk), .fifo_count(fifo_count),
    .err_frame(err_frame), .err_parity(err_parity), .overflow(overflow),
    .fsm_state(fsm_state)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: events as {ext, brk, code}.
  logic [10:0] exp_q[$];
  bit m_ext = 0, m_brk = 0, exp_ovf = 0;
  int exp_ferr = 0, exp_perr = 0, ferr_cnt = 0, perr_cnt = 0, pop_cnt = 0;
  int ready_mode = 0;

  function automatic void model_frame(input logic [7:0] b, input logic bad_par,
                                      input logic bad_stop, input int nbits);
    if (nbits < 8 || bad_stop) begin
      exp_ferr++;
      m_ext = 0; m_brk = 0;
    end else if (bad_par && PAR_EN) begin
      exp_perr++;
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else                           exp_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // out_ready: 0 = held low, 1 = held high, 2 = random each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (RESET_N) begin
      if (err_frame)  ferr_cnt++;
      if (err_parity) perr_cnt++;
      if (out_valid && out_ready) begin
        pop_cnt++;
        check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("pop_event", {out_ext, out_brk, out_code}, exp_q.pop_front());
      end
    end
  end

  task automatic ps2_bit(input logic v);
    @(negedge clk) PS2_DAT = v;
    repeat (15) @(negedge clk);
    PS2_CLK = 1'b0;
    repeat (30) @(negedge clk);
    PS2_CLK = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                          input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    if (nbits == 8) begin
      ps2_bit(~(^b) ^ bad_par);
      ps2_bit(~bad_stop);
    end
    PS2_DAT = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits);
    model_frame(b, bad_par, bad_stop, nbits);
    send_raw(b, bad_par, bad_stop, nbits);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_frame"}, ferr_cnt, exp_ferr);
    check({tag, "_err_parity"}, perr_cnt, exp_perr);
  endtask

  task automatic drain(input string tag);
    ready_mode = 1;
    for (int i = 0; i < 200; i++) begin
      if (!out_valid) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check({tag, "_drained"}, out_valid, 1'b0);
    check({tag, "_model_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_head"}, {out_ext, out_brk, out_code}, 0);
    check({tag, "_errs"}, {err_frame, err_parity}, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_fsm_idle"}, fsm_state, 0);
  endtask

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [7:0] b;
    RESET_N = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    RESET_N = 1'b1;
    repeat (5) @(negedge clk);

    // Single make code delivered straight through.
    ready_mode = 1;
    p0 = pop_cnt;
    send_frame(8'h1C, 0, 0, 8);
    check("rx_1c_pops", pop_cnt - p0, 1);
    check_errs("rx_1c");

    // Extended break sequence collapses into one event.
    ready_mode = 0;
    repeat (4) @(negedge clk);
    send_frame(8'hE0, 0, 0, 8);
    send_frame(8'hF0, 0, 0, 8);
    send_frame(8'h74, 0, 0, 8);
    check("e0f074_count", fifo_count, 1);
    check("e0f074_head", {out_ext, out_brk, out_code}, {1'b1, 1'b1, 8'h74});
    drain("e0f074");

    // Wrong parity bit.
    ready_mode = 0;
    repeat (4) @(negedge clk);
    send_frame(8'h1C, 1, 0, 8);
    check("badpar_count", fifo_count, exp_q.size());
    check_errs("badpar");
    drain("badpar");

    // Truncated frame is aborted only after the idle timeout.
    send_frame(8'h1C, 0, 0, 4);
    repeat (TIMEOUT_CYCLES - 100) @(negedge clk);
    check("timeout_not_early", ferr_cnt, exp_ferr - 1);
    repeat (200) @(negedge clk);
    check_errs("timeout");
    check("timeout_fsm_idle", fsm_state, 0);
    p0 = pop_cnt;
    send_frame(8'h29, 0, 0, 8);
    check("after_timeout_pops", pop_cnt - p0, 1);

    // Bad stop bit after an E0 prefix discards the prefix too.
    send_frame(8'hE0, 0, 0, 8);
    send_frame(8'h55, 0, 1, 8);
    send_frame(8'h15, 0, 0, 8);
    check_errs("badstop");

    // Two-cycle glitch on PS2_CLK with DAT low must not start a frame.
    @(negedge clk) PS2_DAT = 1'b0;
    repeat (5) @(negedge clk);
    PS2_CLK = 1'b0;
    repeat (2) @(negedge clk);
    PS2_CLK = 1'b1;
    repeat (5) @(negedge clk);
    PS2_DAT = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_fsm_idle", fsm_state, 0);
    p0 = pop_cnt;
    send_frame(8'h29, 0, 0, 8);
    check("after_glitch_pops", pop_cnt - p0, 1);
    check_errs("glitch");

    // Nine events into an eight-deep FIFO.
    ready_mode = 0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 8);
    check("full_count", fifo_count, exp_q.size());
    check("full_count_is_depth", fifo_count, FIFO_DEPTH);
    check("overflow_set", overflow, exp_ovf);
    check("full_head", out_code, 8'h01);
    drain("full");
    check("overflow_sticky", overflow, 1'b1);

    // Randomised traffic with a random consumer.
    ready_mode = 2;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0), 8);
      check_errs("rand");
    end
    check("rand_overflow", overflow, exp_ovf);
    drain("rand");

    // One-cycle reset in the middle of a frame with an event buffered.
    ready_mode = 0;
    repeat (4) @(negedge clk);
    send_frame(8'h33, 0, 0, 8);
    check("prereset_count", fifo_count, 1);
    send_raw(8'h1C, 0, 0, 4);
    @(negedge clk) RESET_N = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    RESET_N = 1'b1;
    exp_q.delete();
    m_ext = 0; m_brk = 0; exp_ovf = 0;
    repeat (20) @(negedge clk);
    ready_mode = 1;
    p0 = pop_cnt;
    send_frame(8'h1C, 0, 0, 8);
    check("after_reset_pops", pop_cnt - p0, 1);
    repeat (TIMEOUT_CYCLES + 50) @(negedge clk);
    check_errs("after_reset");
    check("final_overflow", overflow, exp_ovf);
    check("final_fsm_idle", fsm_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
